delayfall_counter: RTL and testbench

- Clocked falling-edge delay cell, the counterpart to the fixed rise-edge delay cells in the step-down control loop.
- A rising edge on i propagates to o after synchronizer latency only.
- A falling edge on i is held off for DELAY_CYCLES clocks before o falls.
- If i returns high during the hold-off, the pending fall is aborted and o never drops.
- Used as a minimum-on-time stretcher in the step-down loop control path.

---
 rtl/delayfall_counter.sv | 149 ++++++++++++++
 tb/tb_delayfall_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/delayfall_counter.sv
// rtl/delayfall_counter.sv - falling-edge delay cell: rise passes after sync latency, fall held off DELAY_CYCLES clocks
// Doubles as a minimum-on-time stretcher; a re-rise during the hold-off cancels the pending fall.
module delayfall_counter #(
    parameter int DELAY_CYCLES = 10,
    parameter int CNT_W        = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             CELCLK,
    input  logic             CELRST,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             CELSUB,
    input  logic             i,
    output logic             o,
    output logic             busy,
    output logic             fall_pulse,
    output logic             abort_pulse,
    output logic [CNT_W-1:0] abort_cnt
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_HIGH     = 2'b01,
        ST_FALLWAIT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_VAL = (DELAY_CYCLES > 0) ? CNT_W'(DELAY_CYCLES - 1) : '0;

    generate
        if (DELAY_CYCLES < 0 || DELAY_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_delay
            $error("delayfall_counter: DELAY_CYCLES does not fit in CNT_W bits");
        end
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("delayfall_counter: SYNC_STAGES must be at least 1");
        end
    endgenerate

    // Supply/substrate pins exist only for the cell footprint.
    logic w_unused_pins;
    assign w_unused_pins = CELV ^ CELG ^ CELSUB;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_i_s;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       r_abort_cnt;
    logic [CNT_W-1:0]       w_abort_cnt_nxt;
    logic                   r_o;
    logic                   r_busy;
    logic                   r_fall_pulse;
    logic                   r_abort_pulse;
    logic                   w_o_nxt;
    logic                   w_busy_nxt;
    logic                   w_fall_nxt;
    logic                   w_abort_nxt;

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_i_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            r_state       <= ST_LOW;
            r_cnt         <= '0;
            r_abort_cnt   <= '0;
            r_o           <= 1'b0;
            r_busy        <= 1'b0;
            r_fall_pulse  <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_abort_cnt   <= w_abort_cnt_nxt;
            r_o           <= w_o_nxt;
            r_busy        <= w_busy_nxt;
            r_fall_pulse  <= w_fall_nxt;
            r_abort_pulse <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_abort_cnt_nxt = r_abort_cnt;
        w_fall_nxt      = 1'b0;
        w_abort_nxt     = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_i_s) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!w_i_s) begin
                    if (DELAY_CYCLES > 0) begin
                        w_state_nxt = ST_FALLWAIT;
                        w_cnt_nxt   = LOAD_VAL;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_fall_nxt  = 1'b1;
                    end
                end
            end
            ST_FALLWAIT: begin
                if (w_i_s) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_abort_nxt = 1'b1;
                    if (r_abort_cnt != CNT_MAX) begin
                        w_abort_cnt_nxt = r_abort_cnt + CNT_ONE;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_LOW;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
        // Outputs are registered copies of the next state so o and the pulses land on the same edge.
        w_o_nxt    = (w_state_nxt != ST_LOW);
        w_busy_nxt = (w_state_nxt == ST_FALLWAIT);
    end

    assign o           = r_o;
    assign busy        = r_busy;
    assign fall_pulse  = r_fall_pulse;
    assign abort_pulse = r_abort_pulse;
    assign abort_cnt   = r_abort_cnt;

endmodule

// File: tb/tb_delayfall_counter.sv
// tb/tb_delayfall_counter.sv - randomized self-checking bench for delayfall_counter against a sliding-window model
module tb_delayfall_counter;

    localparam int S    = 2;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] iv  = '0;
    logic [2:0] ov, bv, fv, av;
    logic [7:0] ac0, ac2;
    logic [1:0] ac1;

    always #5 clk = ~clk;

    delayfall_counter #(.DELAY_CYCLES(10), .CNT_W(8), .SYNC_STAGES(2)) u_d10 (
        .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(iv[0]), .o(ov[0]), .busy(bv[0]), .fall_pulse(fv[0]), .abort_pulse(av[0]), .abort_cnt(ac0));

    delayfall_counter #(.DELAY_CYCLES(3), .CNT_W(2), .SYNC_STAGES(2)) u_sat (
        .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(iv[1]), .o(ov[1]), .busy(bv[1]), .fall_pulse(fv[1]), .abort_pulse(av[1]), .abort_cnt(ac1));

    delayfall_counter #(.DELAY_CYCLES(0), .CNT_W(8), .SYNC_STAGES(2)) u_d0 (
        .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .CELSUB(1'b0),
        .i(iv[2]), .o(ov[2]), .busy(bv[2]), .fall_pulse(fv[2]), .abort_pulse(av[2]), .abort_cnt(ac2));

    int dly[3] = '{10, 3, 0};
    int cap[3] = '{255, 3, 255};
    bit ia[3][MAXE];
    bit cur[3];
    int cnt_m[3];
    int edge_n     = 0;
    int first_edge = 0;
    int n_chk      = 0;
    int n_pass     = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Model: i_s at edge k is i driven S edges earlier; o is the OR of i_s over the last DELAY+1 edges.
    function automatic bit s_at(input int d, input int k);
        if (k - S < first_edge || k - S < 0 || k - S >= MAXE) return 1'b0;
        return ia[d][k-S];
    endfunction

    function automatic bit o_at(input int d, input int k);
        bit r = 1'b0;
        if (k < first_edge) return 1'b0;
        for (int j = k - dly[d]; j <= k; j++) r |= s_at(d, j);
        return r;
    endfunction

    function automatic bit busy_at(input int d, input int k);
        return o_at(d, k) && !s_at(d, k);
    endfunction

    function automatic int cnt_of(input int d);
        if (d == 0) return int'(ac0);
        if (d == 1) return int'(ac1);
        return int'(ac2);
    endfunction

    task automatic step();
        for (int d = 0; d < 3; d++) begin
            ia[d][edge_n+1] = cur[d];
            iv[d] = cur[d];
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (busy_at(d, edge_n - 1) && s_at(d, edge_n))
                cnt_m[d] = (cnt_m[d] < cap[d]) ? cnt_m[d] + 1 : cap[d];
            check($sformatf("d%0d_o@%0d", d, edge_n), ov[d], o_at(d, edge_n));
            check($sformatf("d%0d_busy@%0d", d, edge_n), bv[d], busy_at(d, edge_n));
            check($sformatf("d%0d_fall@%0d", d, edge_n), fv[d], o_at(d, edge_n - 1) && !o_at(d, edge_n));
            check($sformatf("d%0d_abort@%0d", d, edge_n), av[d], busy_at(d, edge_n - 1) && s_at(d, edge_n));
            check($sformatf("d%0d_acnt@%0d", d, edge_n), cnt_of(d), cnt_m[d]);
        end
    endtask

    task automatic apply_reset();
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_d%0d_o", d), ov[d], 0);
            check($sformatf("rst_d%0d_busy", d), bv[d], 0);
            check($sformatf("rst_d%0d_pulses", d), fv[d] | av[d], 0);
            check($sformatf("rst_d%0d_acnt", d), cnt_of(d), 0);
        end
        repeat (2) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        rst = 1'b0;
        first_edge = edge_n + 1;
        for (int d = 0; d < 3; d++) cnt_m[d] = 0;
    endtask

    int t0, n, nb, nl, na, nh, nf;
    int exp_sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        cur = '{0, 0, 0};
        apply_reset();
        repeat (4) step();

        t0 = edge_n; cur[0] = 1'b1; n = 0;
        while (!ov[0] && n < 10) begin step(); n++; end
        check("rise_lat", edge_n - t0, 3);

        repeat (20) step();
        t0 = edge_n; cur[0] = 1'b0; n = 0; nb = 0;
        while (ov[0] && n < 30) begin step(); n++; if (bv[0]) nb++; end
        check("fall_lat", edge_n - t0, 13);
        check("fall_busy_cycles", nb, 10);
        check("fall_pulse_with_o0", fv[0], 1);

        cur[0] = 1'b1; repeat (10) step();
        cur[0] = 1'b0; nl = 0; na = 0;
        repeat (4) begin step(); if (!ov[0]) nl++; if (av[0]) na++; end
        cur[0] = 1'b1;
        repeat (6) begin step(); if (!ov[0]) nl++; if (av[0]) na++; end
        check("abort_o_low_cycles", nl, 0);
        check("abort_pulses", na, 1);
        check("abort_cnt", int'(ac0), 1);
        check("abort_busy_dropped", bv[0], 0);

        cur[0] = 1'b0; repeat (20) step();
        cur[0] = 1'b1; step();
        cur[0] = 1'b0; nh = 0; nf = 0;
        repeat (20) begin step(); nh += int'(ov[0]); nf += int'(fv[0]); end
        check("glitch_on_time", nh, 11);
        check("glitch_fall_pulses", nf, 1);

        cur[0] = 1'b1; repeat (6) step();
        cur[0] = 1'b0; repeat (7) step();
        check("pre_rst_busy", bv[0], 1);
        apply_reset();
        repeat (5) step();

        cur[1] = 1'b1; repeat (4) step();
        for (int a = 0; a < 5; a++) begin
            cur[1] = 1'b0; step();
            cur[1] = 1'b1; repeat (4) step();
            check($sformatf("sat_cnt_%0d", a), int'(ac1), exp_sat[a]);
        end

        cur[2] = 1'b1; repeat (6) step();
        t0 = edge_n; cur[2] = 1'b0; n = 0;
        while (ov[2] && n < 10) begin step(); n++; end
        check("d0_fall_lat", edge_n - t0, 3);
        check("d0_fall_pulse", fv[2], 1);

        for (int r = 0; r < 1500; r++) begin
            for (int d = 0; d < 3; d++)
                if ($urandom_range(0, 99) < 15) cur[d] = !cur[d];
            if (r == 700) apply_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
